// File: rtl/mp_regfile_pkg.sv
// regfile_pkg: shared defaults and packed-port slicing helper for mp_regfile
//   XLEN_D / NREG_D : default register width and register count
//   sl(p, w)        : low bit index of element p in a packed vector of w-bit elements
package regfile_pkg;
    localparam int XLEN_D = 64;
    localparam int NREG_D = 32;
    function automatic int sl(input int p, input int w);
        return p * w;
    endfunction
endpackage

// File: rtl/mp_regfile_scoreboard.sv
// regfile_scoreboard: per-register busy bits with issue/writeback/flush control
//   clk, rst           : clock, synchronous active-high reset
//   iss_en, iss_addr   : mark destination register busy
//   wr_en, wr_addr     : writebacks clear their register's busy bit
//   flush              : clear every busy bit
//   busy_next          : next-state busy bits (used for same-edge read consistency)
//   busy_vec           : registered busy bits
module regfile_scoreboard
    import regfile_pkg::*;
#(
    parameter int NREG     = NREG_D,
    parameter int NWR      = 1,
    parameter int ZERO_REG = 1,
    parameter int AW       = $clog2(NREG)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              iss_en,
    input  logic [AW-1:0]     iss_addr,
    input  logic [NWR-1:0]    wr_en,
    input  logic [NWR*AW-1:0] wr_addr,
    input  logic              flush,
    output logic [NREG-1:0]   busy_next,
    output logic [NREG-1:0]   busy_vec
);
    // Clears are applied first so an issue in the same cycle overrides them.
    always_comb begin
        busy_next = flush ? '0 : busy_vec;
        for (int w = 0; w < NWR; w++)
            if (wr_en[w]) busy_next[wr_addr[sl(w, AW) +: AW]] = 1'b0;
        if (iss_en) busy_next[iss_addr] = 1'b1;
        if (ZERO_REG != 0) busy_next[0] = 1'b0;
    end

    always_ff @(posedge clk)
        busy_vec <= rst ? '0 : busy_next;
endmodule

// File: rtl/mp_regfile.sv
// mp_regfile: multi-port register file with write-to-read bypass and busy scoreboard
//   clk, rst                  : clock, synchronous active-high reset
//   rd_en/rd_addr             : per-port read request (packed addresses)
//   rd_data/rd_busy           : registered read data and busy flag, held when rd_en=0
//   wr_en/wr_addr/wr_data     : per-port writes, highest-index port wins on collision
//   iss_en/iss_addr, flush    : scoreboard control
//   busy_vec                  : registered busy bits
module mp_regfile
    import regfile_pkg::*;
#(
    parameter int XLEN     = XLEN_D,
    parameter int NREG     = NREG_D,
    parameter int NRD      = 2,
    parameter int NWR      = 1,
    parameter int ZERO_REG = 1,
    localparam int AW      = $clog2(NREG)
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [NRD-1:0]      rd_en,
    input  logic [NRD*AW-1:0]   rd_addr,
    output logic [NRD*XLEN-1:0] rd_data,
    output logic [NRD-1:0]      rd_busy,
    input  logic [NWR-1:0]      wr_en,
    input  logic [NWR*AW-1:0]   wr_addr,
    input  logic [NWR*XLEN-1:0] wr_data,
    input  logic                iss_en,
    input  logic [AW-1:0]       iss_addr,
    input  logic                flush,
    output logic [NREG-1:0]     busy_vec
);
    logic [XLEN-1:0] mem [NREG];
    logic [XLEN-1:0] rd_next [NRD];
    logic [NREG-1:0] busy_next;

    regfile_scoreboard #(.NREG(NREG), .NWR(NWR), .ZERO_REG(ZERO_REG), .AW(AW)) u_sb (
        .clk(clk), .rst(rst), .iss_en(iss_en), .iss_addr(iss_addr),
        .wr_en(wr_en), .wr_addr(wr_addr), .flush(flush),
        .busy_next(busy_next), .busy_vec(busy_vec)
    );

    // Ascending port order makes the highest-index matching write the one that sticks.
    always_ff @(posedge clk)
        if (rst)
            for (int i = 0; i < NREG; i++) mem[i] <= '0;
        else
            for (int w = 0; w < NWR; w++)
                if (wr_en[w] && !(ZERO_REG != 0 && wr_addr[sl(w, AW) +: AW] == '0))
                    mem[wr_addr[sl(w, AW) +: AW]] <= wr_data[sl(w, XLEN) +: XLEN];

    always_comb
        for (int p = 0; p < NRD; p++) begin
            rd_next[p] = mem[rd_addr[sl(p, AW) +: AW]];
            for (int w = 0; w < NWR; w++)
                if (wr_en[w] && wr_addr[sl(w, AW) +: AW] == rd_addr[sl(p, AW) +: AW])
                    rd_next[p] = wr_data[sl(w, XLEN) +: XLEN];
            if (ZERO_REG != 0 && rd_addr[sl(p, AW) +: AW] == '0) rd_next[p] = '0;
        end

    always_ff @(posedge clk)
        if (rst) begin
            rd_data <= '0;
            rd_busy <= '0;
        end else
            for (int p = 0; p < NRD; p++)
                if (rd_en[p]) begin
                    rd_data[sl(p, XLEN) +: XLEN] <= rd_next[p];
                    rd_busy[p] <= busy_next[rd_addr[sl(p, AW) +: AW]];
                end
endmodule

// File: tb/tb_mp_regfile.sv
// tb_mp_regfile: randomized + directed scoreboard bench for mp_regfile (NRD=2, NWR=2)
module tb_mp_regfile;
    logic         clk = 0;
    logic         rst;
    logic [1:0]   rd_en;
    logic [9:0]   rd_addr;
    logic [127:0] rd_data;
    logic [1:0]   rd_busy;
    logic [1:0]   wr_en;
    logic [9:0]   wr_addr;
    logic [127:0] wr_data;
    logic         iss_en;
    logic [4:0]   iss_addr;
    logic         flush;
    logic [31:0]  busy_vec;

    mp_regfile #(.XLEN(64), .NREG(32), .NRD(2), .NWR(2), .ZERO_REG(1)) dut (
        .clk(clk), .rst(rst), .rd_en(rd_en), .rd_addr(rd_addr), .rd_data(rd_data),
        .rd_busy(rd_busy), .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
        .iss_en(iss_en), .iss_addr(iss_addr), .flush(flush), .busy_vec(busy_vec)
    );

    always #5 clk = ~clk;

    typedef struct {
        int           cyc;
        logic [127:0] d;
        logic [1:0]   b;
        logic [31:0]  bv;
    } exp_t;

    exp_t        q[$];
    int          edge_cnt = 0;
    int          checks = 0;
    int          failures = 0;

    logic [63:0] m_reg [32];
    bit          m_busy [32];
    logic [63:0] m_hd [2];
    bit          m_hb [2];

    // Monitor: outputs settle after each edge; compare every expectation tagged for it.
    always @(posedge clk) begin
        #1;
        edge_cnt++;
        while (q.size() > 0 && q[0].cyc <= edge_cnt) begin
            exp_t e;
            e = q.pop_front();
            checks += 3;
            if (rd_data !== e.d) begin
                failures++;
                $display("FAIL rd_data edge=%0d got=%h exp=%h", edge_cnt, rd_data, e.d);
            end
            if (rd_busy !== e.b) begin
                failures++;
                $display("FAIL rd_busy edge=%0d got=%b exp=%b", edge_cnt, rd_busy, e.b);
            end
            if (busy_vec !== e.bv) begin
                failures++;
                $display("FAIL busy_vec edge=%0d got=%h exp=%h", edge_cnt, busy_vec, e.bv);
            end
        end
    end

    // Reference model: architectural register state and busy set, updated per cycle,
    // then the expected outputs after the coming edge are queued.
    task automatic step();
        exp_t e;
        if (rst) begin
            for (int i = 0; i < 32; i++) begin
                m_reg[i] = '0;
                m_busy[i] = 0;
            end
            m_hd[0] = '0; m_hd[1] = '0;
            m_hb[0] = 0;  m_hb[1] = 0;
        end else begin
            for (int w = 0; w < 2; w++)
                if (wr_en[w] && wr_addr[w*5 +: 5] != 0)
                    m_reg[wr_addr[w*5 +: 5]] = wr_data[w*64 +: 64];
            if (flush)
                for (int i = 0; i < 32; i++) m_busy[i] = 0;
            for (int w = 0; w < 2; w++)
                if (wr_en[w]) m_busy[wr_addr[w*5 +: 5]] = 0;
            if (iss_en) m_busy[iss_addr] = 1;
            m_busy[0] = 0;
            for (int p = 0; p < 2; p++)
                if (rd_en[p]) begin
                    m_hd[p] = m_reg[rd_addr[p*5 +: 5]];
                    m_hb[p] = m_busy[rd_addr[p*5 +: 5]];
                end
        end
        e.cyc = edge_cnt + 1;
        e.d = {m_hd[1], m_hd[0]};
        e.b = {m_hb[1], m_hb[0]};
        for (int i = 0; i < 32; i++) e.bv[i] = m_busy[i];
        q.push_back(e);
        @(negedge clk);
    endtask

    task automatic idle();
        rst = 0; rd_en = '0; rd_addr = '0; wr_en = '0; wr_addr = '0; wr_data = '0;
        iss_en = 0; iss_addr = '0; flush = 0;
    endtask

    task automatic wr(input int w, input logic [4:0] a, input logic [63:0] d);
        wr_en[w] = 1; wr_addr[w*5 +: 5] = a; wr_data[w*64 +: 64] = d;
    endtask

    task automatic rd(input int p, input logic [4:0] a);
        rd_en[p] = 1; rd_addr[p*5 +: 5] = a;
    endtask

    initial begin
        idle();
        rst = 1;
        @(negedge clk);
        step(); step();
        // reset after preload
        idle(); wr(0, 5'd4, 64'h1234); wr(1, 5'd6, 64'h5678); iss_en = 1; iss_addr = 5'd8; step();
        idle(); rst = 1; wr(0, 5'd9, 64'h77); iss_en = 1; iss_addr = 5'd9; step();
        idle(); rd(0, 5'd4); rd(1, 5'd6); step();
        // basic write then read
        idle(); wr(0, 5'd5, 64'hDEADBEEF_00000001); step();
        idle(); rd(0, 5'd5); step();
        // collision with same-cycle bypass, then plain read
        idle(); wr(0, 5'd7, 64'd1); wr(1, 5'd7, 64'd2); rd(0, 5'd7); rd(1, 5'd7); step();
        idle(); rd(1, 5'd7); step();
        // zero register
        idle(); wr(0, 5'd0, 64'hFFFF); iss_en = 1; iss_addr = 5'd0; rd(0, 5'd0); step();
        idle(); rd(1, 5'd0); step();
        // scoreboard
        idle(); iss_en = 1; iss_addr = 5'd3; step();
        idle(); rd(0, 5'd3); step();
        idle(); wr(1, 5'd3, 64'h33); iss_en = 1; iss_addr = 5'd3; rd(0, 5'd3); step();
        idle(); wr(0, 5'd3, 64'h34); rd(1, 5'd3); step();
        idle(); iss_en = 1; iss_addr = 5'd12; step();
        idle(); flush = 1; iss_en = 1; iss_addr = 5'd9; rd(0, 5'd9); rd(1, 5'd12); step();
        // hold while disabled
        idle(); rd(0, 5'd5); step();
        idle(); wr(0, 5'd5, 64'd42); step();
        idle(); step();
        idle(); rd(0, 5'd5); step();
        // random traffic over a narrow address window to force collisions and bypasses
        for (int n = 0; n < 3000; n++) begin
            idle();
            rst = ($urandom_range(0, 199) == 0);
            flush = ($urandom_range(0, 29) == 0);
            iss_en = $urandom_range(0, 1);
            iss_addr = 5'($urandom_range(0, 7));
            for (int k = 0; k < 2; k++) begin
                if ($urandom_range(0, 1) == 1) wr(k, 5'($urandom_range(0, 7)), {$urandom, $urandom});
                if ($urandom_range(0, 3) != 0) rd(k, 5'($urandom_range(0, 7)));
            end
            step();
        end
        idle();
        step();
        repeat (4) @(negedge clk);
        checks++;
        if (q.size() != 0) begin
            failures++;
            $display("FAIL drain pending=%0d exp=0", q.size());
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/mp_regfile.md
# mp_regfile

Parametrised multi-port register file with write-to-read bypass and a per-register busy scoreboard, for the pipelined core's decode/writeback boundary. Provides NRD synchronous read ports and NWR write ports, with an optional hardwired-zero register 0. A busy bit per register is set at issue and cleared at writeback, so decode can detect RAW hazards without a separate hazard table.

## Interface
Parameters:
- XLEN, 64, register width in bits
- NREG, 32, number of registers, power of two ≥ 2; AW = $clog2(NREG) (localparam)
- NRD, 2, number of read ports, ≥ 1
- NWR, 1, number of write ports, ≥ 1
- ZERO_REG, 1, when 1 register 0 reads 0, ignores writes and is never busy

Ports:
- clk  in  1  clock, all state updates on posedge
- rst  in  1  reset, synchronous, active-high
- rd_en  in  NRD  per-port read enable
- rd_addr  in  NRD*AW  packed read addresses, port p at [p*AW +: AW]
- rd_data  out  NRD*XLEN  packed registered read data
- rd_busy  out  NRD  registered busy flag of the addressed register
- wr_en  in  NWR  per-port write enable
- wr_addr  in  NWR*AW  packed write addresses
- wr_data  in  NWR*XLEN  packed write data
- iss_en  in  1  mark iss_addr busy (instruction issued with destination)
- iss_addr  in  AW  destination of issued instruction
- flush  in  1  clear all busy bits (pipeline flush)
- busy_vec  out  NREG  current busy bits, bit i = register i

## Operation
- Reset: all registers 0, all busy bits 0, rd_data 0, rd_busy 0, busy_vec 0. No preload values.
- Write: on posedge, each wr_en[w] writes wr_data[w] to wr_addr[w]. If ZERO_REG=1 and the address is 0, the write is dropped.
- Write collision (same address on several ports in one cycle): the highest-index port wins.
- Read: on posedge with rd_en[p]=1, rd_data[p] loads the addressed register value. With rd_en[p]=0, rd_data[p] and rd_busy[p] hold.
- Bypass: when a read address matches an enabled write in the same cycle, rd_data takes that write's data, using the winning port under collision. ZERO_REG address 0 always returns 0.
- Scoreboard next-state per register r:
  - flush, or a write to r, clears the bit.
  - iss_en with iss_addr==r then sets it. Set takes priority over both clear and flush in the same cycle.
  - Otherwise the bit holds.
  - ZERO_REG=1 keeps bit 0 at 0.
- rd_busy[p] loads the next-state busy bit of rd_addr[p], consistent with the bypassed data.
- rst has priority over every other input in the same cycle. Asserting it mid-operation discards pending writes and issues.
- No arithmetic: data passes through unmodified. Addresses are always in range because NREG is a power of two.

## Timing
- Read latency 1 cycle: address and rd_en at edge N give rd_data/rd_busy valid after edge N.
- Write to read visibility: 0 extra cycles, because of the bypass on the same edge.
- busy_vec is a direct register output, updated on the same edge as the scoreboard.
- Issue to busy visible on busy_vec: 1 cycle. Writeback clear: 1 cycle.
- No handshake and no stalls: every port is accepted every cycle.

## Structure
- Package regfile_pkg holds:
  - defaults XLEN_D=64, NREG_D=32
  - a helper function returning the slice index for packed ports
- Sub-module regfile_scoreboard owns the busy bits, set/clear/flush priority and ZERO_REG masking. Its interface:
  - inputs: iss_en, iss_addr, wr_en, wr_addr, flush
  - outputs: busy_next, busy_vec
- mp_regfile instantiates regfile_scoreboard and owns the storage array, write-collision resolution, bypass mux and read registers.

## Test plan
- Reset: preload via writes, assert rst 1 cycle → all reads return 0, busy_vec=0, rd_data=0 the cycle after.
- Basic write/read: write x5=64'hDEADBEEF_00000001, read x5 next cycle → rd_data=64'hDEADBEEF_00000001, latency 1.
- Bypass and collision (NWR=2): same cycle wr0 x7=1, wr1 x7=2, read x7 → rd_data=2; the next read of x7 is also 2.
- Zero register: write x0=64'hFFFF, iss_en to x0, read x0 → rd_data=0, rd_busy=0, busy_vec[0]=0.
- Scoreboard: issue x3, then x3 busy_vec=1. A write to x3 plus iss_en x3 in the same cycle leaves it busy. A write alone clears it. flush together with issue x9 → only bit 9 set.
- Hold: rd_en=0 while x5 is rewritten to 42 → rd_data holds the old value; it updates to 42 only after rd_en=1.
